// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared encodings for the multiply/divide unit
package mult_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/twos_abs.sv
// rtl/twos_abs.sv - two's-complement magnitude and sign extraction
// force_neg negates unconditionally so the same negator serves sign correction.
module twos_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             is_signed,
  input  logic             force_neg,
  output logic [WIDTH-1:0] mag,
  output logic             sign
);

  logic [WIDTH-1:0] neg;

  assign sign = is_signed & value[WIDTH-1];
  assign neg  = '0 - value;
  assign mag  = (sign | force_neg) ? neg : value;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// One shift-add or restoring shift-subtract step per CALC cycle, sign fix in FIX.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic               is_div_q;
  logic               res_neg;
  logic               dvd_neg;

  logic               div_op;
  logic               signed_op;
  logic               in_fix;
  logic [WIDTH-1:0]   val_a;
  logic [WIDTH-1:0]   val_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_neg;
  logic [WIDTH-1:0]   hi_fix;

  assign div_op    = op_is_div(op);
  assign signed_op = op_is_signed(op);
  assign in_fix    = (state == ST_FIX);

  // In IDLE the two negators take the operands; in FIX they are reused to
  // correct lo/quotient (a-side) and hi/remainder (b-side).
  always_comb begin
    val_a = a;
    val_b = b;
    if (in_fix) begin
      val_a = acc[WIDTH-1:0];
      val_b = is_div_q ? rem[WIDTH-1:0] : acc[2*WIDTH-1:WIDTH];
    end
  end

  twos_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value     (val_a),
    .is_signed (signed_op & ~in_fix),
    .force_neg (in_fix & res_neg),
    .mag       (mag_a),
    .sign      (sign_a)
  );

  twos_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value     (val_b),
    .is_signed (signed_op & ~in_fix),
    .force_neg (in_fix & (is_div_q ? dvd_neg : res_neg)),
    .mag       (mag_b),
    .sign      (sign_b)
  );

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    div_shift = {rem, acc[WIDTH-1]};
    div_diff  = div_shift - {2'b00, opnd};
    div_neg   = div_diff[WIDTH+1];
    // Negating the 2W product: the upper half only takes the +1 carry when the lower half is zero.
    hi_fix    = (res_neg && (acc[WIDTH-1:0] != '0)) ? ~acc[2*WIDTH-1:WIDTH] : mag_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      opnd     <= '0;
      acc      <= '0;
      rem      <= '0;
      is_div_q <= 1'b0;
      res_neg  <= 1'b0;
      dvd_neg  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (div_op && (b == '0)) begin
              div_zero <= 1'b1;
              done     <= 1'b1;
              state    <= ST_DONE;
            end else begin
              div_zero <= 1'b0;
              busy     <= 1'b1;
              cnt      <= CW'(WIDTH - 1);
              is_div_q <= div_op;
              res_neg  <= sign_a ^ sign_b;
              dvd_neg  <= sign_a;
              rem      <= '0;
              opnd     <= div_op ? mag_b : mag_a;
              acc      <= {{WIDTH{1'b0}}, (div_op ? mag_a : mag_b)};
              state    <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (is_div_q) begin
            rem <= div_neg ? div_shift[WIDTH:0] : div_diff[WIDTH:0];
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~div_neg};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          lo    <= mag_a;
          hi    <= is_div_q ? mag_b : hi_fix;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised, sequential multiply/divide unit for the multicycle CPU datapath; it executes MULT, MULTU, DIV and DIVU.
- Operands come from the register file outputs (A/B registers). Results go to architectural HI/LO registers held inside this block.
- The control unit issues a one-cycle start, stalls while busy, and advances on done.
- It is the successor to the ALU-control selection logic: the op field now selects among four iterative modes rather than feeding a combinational mux.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  request pulse; sampled only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start
- a  input  WIDTH  multiplicand / dividend
- b  input  WIDTH  multiplier / divisor
- busy  output  1  high while in CALC or FIX
- done  output  1  one-cycle pulse; HI/LO (or div_zero) valid from this cycle
- div_zero  output  1  high with done when a DIV/DIVU had b==0; held until next accepted start
- hi  output  WIDTH  product upper half / remainder
- lo  output  WIDTH  product lower half / quotient

Behaviour:
- Reset values: state IDLE; busy, done, div_zero = 0; hi, lo = 0; counter and internal registers = 0.
- Reset wins over every other input.
- Reset during CALC or FIX aborts the operation: no done, and hi/lo go to 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, no divide-by-zero:
  - At edge k, latch |a| and |b|; signed ops use two's-complement magnitude, unsigned ops pass the operand through.
  - Also latch the sign of the result and the sign of the dividend, clear div_zero, load counter = WIDTH-1, and go to CALC.
- IDLE, start=1, op DIV/DIVU, b==0:
  - At edge k, go directly to DONE with div_zero=1; hi/lo unchanged.
- CALC: one iteration per cycle, exactly WIDTH cycles (edges k+1..k+WIDTH); the counter decrements and the block leaves CALC when counter==0.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; remainder register WIDTH+1 bits, quotient shifted in LSB-first.
- FIX (edge k+WIDTH+1): apply sign correction, write hi/lo, go to DONE.
  - MULT: negate the 2*WIDTH product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - Unsigned ops: no correction.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: a normal op raises done in the cycle after edge k+WIDTH+1, which is WIDTH+2 cycles after the start cycle. Divide-by-zero raises done 1 cycle after the start cycle.
- start outside IDLE (including DONE) is ignored; operands are not re-sampled.
- a/b/op may change freely after the start cycle.
- Signed overflow: most-negative / -1 gives lo = most-negative (wraps) and hi = 0; no flag.
- hi/lo hold their value between operations and change only in FIX or on reset.
- Zero operands take the full latency; there is no early termination.

Decomposition:
- Shared package mult_div_pkg:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state encoding: ST_IDLE, ST_CALC, ST_FIX, ST_DONE
- One natural sub-module, twos_abs, parametrised by WIDTH: returns the magnitude and the sign bit. It is reused for both operands, and its negation path is reused in FIX.
- FSM, counter and datapath stay in mult_div_unit.

Test Plan:
- MULT a=7, b=FFFFFFFD (-3), WIDTH=32 -> done exactly 34 cycles after the start cycle; hi=FFFFFFFF, lo=FFFFFFEB; busy high for 33 cycles.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Repeat with MULT -> hi=00000000, lo=00000001.
- DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1).
- DIVU a=FFFFFFF9, b=2 -> lo=7FFFFFFC, hi=00000001.
- DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000, div_zero=0.
- DIV b=0 with prior hi/lo=1234/5678 -> done 1 cycle after start, div_zero=1, hi/lo unchanged.
- Then MULT 3*4 -> div_zero clears at that start; hi=0, lo=C.
- Robustness:
  - start pulsed mid-CALC -> ignored, result unchanged.
  - reset asserted at CALC cycle 10 -> next cycle IDLE, hi/lo=0, no done.
  - Rerun with WIDTH=8: MULT 0x85*0x03 -> hi=FE, lo=8F; done at cycle 10.
